mesi_bus_ctrl: RTL and testbench

MESI_BUS_CTRL -- requirements
Module: mesi_bus_ctrl

---
 rtl/mesi_bus_pkg.sv | 26 ++
 rtl/mesi_bus_ctrl_rr_arbiter.sv | 30 +++
 rtl/mesi_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_mesi_bus_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snooping bus controller: FSM states, bus commands, cache line states.
package mesi_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WB,
        MEMRD,
        DONE
    } bus_state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_RD,
        CMD_RDX,
        CMD_UPGR
    } bus_cmd_t;

    typedef enum logic [1:0] {
        MESI_I,
        MESI_S,
        MESI_E,
        MESI_M
    } mesi_states_t;

endpackage

// File: rtl/mesi_bus_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping; one-hot out.
// Zero latency, no state; an empty request vector yields an all-zero grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] first;
    logic         hit;

    // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        first = '0;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !hit) begin
                first[i] = 1'b1;
                hit      = 1'b1;
            end
        end
        gnt = N'(({first, first} << ptr) >> N);
    end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// MESI bus controller: arbitrates BusRd/BusRdX/BusUpgr, broadcasts snoops, runs write-back or memory read.
// UPGR without flush completes SNOOP_CYCLES+1 cycles after the request is seen; memory phases wait on mem_ack.
module mesi_bus_ctrl
    import mesi_bus_pkg::*;
#(
    parameter int NUM_CACHES   = 4,
    parameter int SNOOP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [NUM_CACHES-1:0] req_rd,
    input  logic [NUM_CACHES-1:0] req_rdx,
    input  logic [NUM_CACHES-1:0] req_upgr,
    output logic [NUM_CACHES-1:0] grant,
    output logic                  snoop_rd,
    output logic                  snoop_rdx,
    output logic                  snoop_upgr,
    input  logic [NUM_CACHES-1:0] shared_in,
    input  logic [NUM_CACHES-1:0] flush_in,
    output logic                  c_out,
    output logic [NUM_CACHES-1:0] done,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic                  mem_ack,
    output logic                  err
);

    localparam int PW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    bus_state_t            state;
    bus_cmd_t              cmd;
    logic [NUM_CACHES-1:0] owner_oh;
    logic [PW-1:0]         owner_idx;
    logic [PW-1:0]         rr_ptr;
    logic [3:0]            cnt;
    logic                  shared_acc;
    logic [NUM_CACHES-1:0] flush_acc;
    logic                  err_q;
    logic                  started;

    logic [NUM_CACHES-1:0] req_any;
    logic [NUM_CACHES-1:0] arb_gnt;
    logic [PW-1:0]         arb_idx;
    bus_cmd_t              arb_cmd;
    logic [NUM_CACHES-1:0] flush_now;
    logic                  shared_now;
    logic                  snoop_last;

    assign req_any = req_rd | req_rdx | req_upgr;

    rr_arbiter #(
        .N  (NUM_CACHES),
        .PW (PW)
    ) u_arb (
        .req (req_any),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PW'(i);
            end
        end
        if (|(req_rdx & arb_gnt)) begin
            arb_cmd = CMD_RDX;
        end else if (|(req_upgr & arb_gnt)) begin
            arb_cmd = CMD_UPGR;
        end else begin
            arb_cmd = CMD_RD;
        end
    end

    // Owner's own snoop responses are ignored; include this cycle so the exit decision sees it.
    assign flush_now  = flush_acc | (flush_in & ~owner_oh);
    assign shared_now = shared_acc | (|(shared_in & ~owner_oh));
    assign snoop_last = (cnt == 4'(SNOOP_CYCLES - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            cmd        <= CMD_NONE;
            owner_oh   <= '0;
            owner_idx  <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
            shared_acc <= 1'b0;
            flush_acc  <= '0;
            err_q      <= 1'b0;
            started    <= 1'b0;
        end else begin
            // Holds off arbitration for the first edge after reset release.
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (started && (|req_any)) begin
                        owner_oh   <= arb_gnt;
                        owner_idx  <= arb_idx;
                        cmd        <= arb_cmd;
                        cnt        <= '0;
                        shared_acc <= 1'b0;
                        flush_acc  <= '0;
                        state      <= SNOOP;
                    end
                end
                SNOOP: begin
                    shared_acc <= shared_now;
                    flush_acc  <= flush_now;
                    cnt        <= cnt + 4'd1;
                    if (snoop_last) begin
                        if (((flush_now & (flush_now - 1'b1)) != '0) ||
                            ((cmd == CMD_UPGR) && (|flush_now))) begin
                            err_q <= 1'b1;
                        end
                        if (|flush_now) begin
                            state <= WB;
                        end else if (cmd == CMD_UPGR) begin
                            state <= DONE;
                        end else begin
                            state <= MEMRD;
                        end
                    end
                end
                WB, MEMRD: begin
                    if (mem_ack) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= (owner_idx == PW'(NUM_CACHES - 1)) ? '0 : owner_idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant      = (state != IDLE) ? owner_oh : '0;
    assign snoop_rd   = (state == SNOOP) && (cmd == CMD_RD);
    assign snoop_rdx  = (state == SNOOP) && (cmd == CMD_RDX);
    assign snoop_upgr = (state == SNOOP) && (cmd == CMD_UPGR);
    assign mem_req    = (state == WB) || (state == MEMRD);
    assign mem_we     = (state == WB);
    assign done       = (state == DONE) ? owner_oh : '0;
    assign c_out      = (state == DONE) && (cmd == CMD_RD) && (shared_acc || (|flush_acc));
    assign err        = err_q;

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Directed bench for mesi_bus_ctrl: inputs change on the falling edge, outputs checked on the falling edge.
module tb_mesi_bus_ctrl;

    logic       clk = 1'b0;
    logic       rstb;
    logic [3:0] req_rd, req_rdx, req_upgr;
    logic [3:0] grant;
    logic       snoop_rd, snoop_rdx, snoop_upgr;
    logic [3:0] shared_in, flush_in;
    logic       c_out;
    logic [3:0] done;
    logic       mem_req, mem_we, mem_ack;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mesi_bus_ctrl #(
        .NUM_CACHES   (4),
        .SNOOP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_rd     (req_rd),
        .req_rdx    (req_rdx),
        .req_upgr   (req_upgr),
        .grant      (grant),
        .snoop_rd   (snoop_rd),
        .snoop_rdx  (snoop_rdx),
        .snoop_upgr (snoop_upgr),
        .shared_in  (shared_in),
        .flush_in   (flush_in),
        .c_out      (c_out),
        .done       (done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .err        (err)
    );

    // {grant, snoop_rd/rdx/upgr, done, c_out, mem_req, mem_we, err}
    wire [14:0] obs = {grant, snoop_rd, snoop_rdx, snoop_upgr, done, c_out, mem_req, mem_we, err};

    function automatic logic [14:0] ex(input logic [3:0] g, input logic [2:0] s, input logic [3:0] d,
                                       input logic c, input logic mr, input logic mw, input logic e);
        return {g, s, d, c, mr, mw, e};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0; req_rd = 4'b1111; req_rdx = '0; req_upgr = '0;
        shared_in = '0; flush_in = '0; mem_ack = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (obs !== 15'd0) begin
            errors++; $display("FAIL reset_hold obs=%b want=%b", obs, 15'd0);
        end
        rstb = 1'b1;
        next_cycle();
        checks++;
        if (obs !== 15'd0) begin
            errors++; $display("FAIL reset_first_edge obs=%b want=%b", obs, 15'd0);
        end
        req_rd = '0;
        next_cycle();
        checks++;
        if (obs !== 15'd0) begin
            errors++; $display("FAIL reset_idle obs=%b want=%b", obs, 15'd0);
        end
    endtask

    task automatic test_round_robin();
        logic [14:0] want;
        logic [3:0]  g;
        int          phase, txn;
        req_rd = 4'b1111; mem_ack = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            next_cycle();
            phase = (c - 1) % 5;
            txn   = (c - 1) / 5;
            g     = 4'b0001 << (txn % 4);
            case (phase)
                0, 1:    want = ex(g, 3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                2:       want = ex(g, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
                3:       want = ex(g, 3'b000, g,       1'b0, 1'b0, 1'b0, 1'b0);
                default: want = 15'd0;
            endcase
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL rr_cycle%0d obs=%b want=%b", c, obs, want);
            end
            if (c == 24) req_rd = '0;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_upgr_withdraw();
        logic [14:0] want;
        req_upgr = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            case (c)
                1, 2:    want = ex(4'b0100, 3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                3:       want = ex(4'b0100, 3'b000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
                default: want = 15'd0;
            endcase
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL upgr_cycle%0d obs=%b want=%b", c, obs, want);
            end
            // Owner drops its request early; the transaction must still finish.
            if (c == 1) req_upgr = '0;
        end
    endtask

    task automatic test_rd_shared();
        logic [14:0] want;
        req_rd = 4'b0001; shared_in = 4'b1000;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            case (c)
                1, 2:       want = ex(4'b0001, 3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                3, 4, 5, 6: want = ex(4'b0001, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
                7:          want = ex(4'b0001, 3'b000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
                default:    want = 15'd0;
            endcase
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL rd_cycle%0d obs=%b want=%b", c, obs, want);
            end
            // Ack outside a memory phase is ignored; the real ack arrives in the 4th mem_req cycle.
            case (c)
                1: mem_ack = 1'b1;
                2: mem_ack = 1'b0;
                6: mem_ack = 1'b1;
                7: begin mem_ack = 1'b0; req_rd = '0; shared_in = '0; end
                default: ;
            endcase
        end
    endtask

    task automatic test_rdx_flush();
        logic [14:0] want;
        // Owner's own flush bit set too: it must not count as a second flusher.
        req_rdx = 4'b0010; flush_in = 4'b0011;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            case (c)
                1, 2:    want = ex(4'b0010, 3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                3:       want = ex(4'b0010, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
                4:       want = ex(4'b0010, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
                default: want = 15'd0;
            endcase
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL rdx_cycle%0d obs=%b want=%b", c, obs, want);
            end
            if (c == 3) mem_ack = 1'b1;
            if (c == 4) begin mem_ack = 1'b0; req_rdx = '0; flush_in = '0; end
        end
    endtask

    task automatic test_err_double_flush();
        logic [14:0] want;
        req_rd = 4'b0100; flush_in = 4'b0011;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            case (c)
                1, 2:    want = ex(4'b0100, 3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                3:       want = ex(4'b0100, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
                4:       want = ex(4'b0100, 3'b000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
                default: want = ex(4'b0000, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
            endcase
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL err_cycle%0d obs=%b want=%b", c, obs, want);
            end
            if (c == 3) mem_ack = 1'b1;
            if (c == 4) begin mem_ack = 1'b0; req_rd = '0; flush_in = '0; end
        end
    endtask

    task automatic test_reset_in_wb();
        logic [14:0] want;
        req_rd = 4'b1000; flush_in = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            want = (c < 3) ? ex(4'b1000, 3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1)
                           : ex(4'b1000, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (obs !== want) begin
                errors++; $display("FAIL rstwb_cycle%0d obs=%b want=%b", c, obs, want);
            end
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (obs !== 15'd0) begin
            errors++; $display("FAIL rstwb_async obs=%b want=%b", obs, 15'd0);
        end
        req_rd = 4'b1001; flush_in = '0;
        @(negedge clk);
        rstb = 1'b1;
        next_cycle();
        checks++;
        if (obs !== 15'd0) begin
            errors++; $display("FAIL rstwb_first_edge obs=%b want=%b", obs, 15'd0);
        end
        next_cycle();
        want = ex(4'b0001, 3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== want) begin
            errors++; $display("FAIL rstwb_ptr0 obs=%b want=%b", obs, want);
        end
        req_rd = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_upgr_withdraw();
        test_rd_shared();
        test_rdx_flush();
        test_err_double_flush();
        test_reset_in_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
